// File: rtl/capture_ctrl_pkg.sv
// Shared capture-path encodings (modes, controller states) and sample helpers.
// Imported by the capture controller, its decimator and the UI block.
package capture_ctrl_pkg;

    localparam int unsigned SampleW   = 16;
    localparam int unsigned DecimCntW = 7;

    typedef enum logic [1:0] {
        ModeRun    = 2'd0,
        ModeStop   = 2'd1,
        ModeSingle = 2'd2,
        ModeRsvd   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StStop  = 2'd0,
        StRun   = 2'd1,
        StArmed = 2'd2,
        StDone  = 2'd3
    } ctrl_state_e;

    // Signed a - b at one extra bit, clamped back into the sample range.
    function automatic logic [SampleW-1:0] sat_sub(input logic [SampleW-1:0] a,
                                                   input logic [SampleW-1:0] b);
        logic [SampleW:0] diff;
        diff = {a[SampleW-1], a} - {b[SampleW-1], b};
        if (diff[SampleW] != diff[SampleW-1]) begin
            sat_sub = diff[SampleW] ? {1'b1, {(SampleW-1){1'b0}}} : {1'b0, {(SampleW-1){1'b1}}};
        end else begin
            sat_sub = diff[SampleW-1:0];
        end
    endfunction

endpackage

// File: rtl/sample_decimator.sv
// Passes one of every 2^decim_sel input strobes; the counter restarts whenever
// decim_sel changes so the first strobe after a change always qualifies.
module sample_decimator
    import capture_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       strobe_in,
    input  logic [2:0] decim_sel,
    output logic       strobe_out
);

    logic [DecimCntW-1:0] cnt_q, cnt_d, cnt_eff, mask;
    logic [2:0]           sel_q, sel_d;

    always_comb begin
        mask       = ~({DecimCntW{1'b1}} << decim_sel);
        cnt_eff    = (decim_sel != sel_q) ? '0 : cnt_q;
        strobe_out = strobe_in && (cnt_eff == '0);
        cnt_d      = strobe_in ? ((cnt_eff + DecimCntW'(1)) & mask) : cnt_eff;
        sel_d      = decim_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: decimates and level-shifts samples into wave_capture and
// gates the display idle flag to implement RUN / STOP / single-shot capture.
module capture_ctrl
    import capture_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               new_sample_ready,
    input  logic [SampleW-1:0] new_sample_in,
    input  logic [2:0]         decim_sel,
    input  logic [SampleW-1:0] trig_level,
    input  logic [1:0]         mode,
    input  logic               arm,
    input  logic               wave_display_idle_in,
    input  logic               read_index,
    output logic               cap_sample_ready,
    output logic [SampleW-1:0] cap_sample,
    output logic               cap_display_idle,
    output logic [15:0]        frame_count,
    output logic [1:0]         ctrl_state
);

    ctrl_state_e        state_q, state_d;
    logic               ready_q, ready_d;
    logic [SampleW-1:0] sample_q, sample_d;
    logic [15:0]        fc_q, fc_d;
    logic               rd_q, rd_d;
    logic               qualify;
    logic               swap;

    sample_decimator u_decim (
        .clk        (clk),
        .reset      (reset),
        .strobe_in  (new_sample_ready),
        .decim_sel  (decim_sel),
        .strobe_out (qualify)
    );

    assign swap = read_index ^ rd_q;

    // Capture datapath runs in every state so the back buffer keeps filling.
    always_comb begin
        ready_d  = qualify;
        sample_d = qualify ? sat_sub(new_sample_in, trig_level) : sample_q;
        fc_d     = swap ? fc_q + 16'd1 : fc_q;
        rd_d     = read_index;
    end

    // Mode decode comes first so a mode change overrides a same-cycle arm or swap.
    always_comb begin
        state_d = state_q;
        unique case (mode_e'(mode))
            ModeRun: state_d = StRun;
            ModeSingle: begin
                unique case (state_q)
                    StStop, StRun: state_d = StDone;
                    StDone:        if (arm) state_d = StArmed;
                    StArmed:       if (swap) state_d = StDone;
                endcase
            end
            ModeStop, ModeRsvd: state_d = StStop;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StStop;
            ready_q  <= 1'b0;
            sample_q <= '0;
            fc_q     <= '0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            sample_q <= sample_d;
            fc_q     <= fc_d;
            rd_q     <= rd_d;
        end
    end

    assign cap_display_idle = wave_display_idle_in && ((state_q == StRun) || (state_q == StArmed));
    assign cap_sample_ready = ready_q;
    assign cap_sample       = sample_q;
    assign frame_count      = fc_q;
    assign ctrl_state       = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomised bench for capture_ctrl: a behavioural model predicts every output,
// captured samples flow through a scoreboard queue popped by an output monitor.
module tb_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_sample_ready = 1'b0;
    logic [15:0] new_sample_in = '0;
    logic [2:0]  decim_sel = '0;
    logic [15:0] trig_level = '0;
    logic [1:0]  mode = 2'd1;
    logic        arm = 1'b0;
    logic        wave_display_idle_in = 1'b0;
    logic        read_index = 1'b0;
    logic        cap_sample_ready;
    logic [15:0] cap_sample;
    logic        cap_display_idle;
    logic [15:0] frame_count;
    logic [1:0]  ctrl_state;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    bit auto_swap = 1'b0;

    // Reference model state (spec-level: strobe count since last decim change).
    int          m_state = 0;
    int          m_fc = 0;
    int          m_n = 0;
    int          m_prev_sel = 0;
    bit          m_prev_rd = 1'b0;
    bit          m_pulse = 1'b0;
    logic [15:0] m_last = '0;
    logic [15:0] sbq[$];

    capture_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .new_sample_ready     (new_sample_ready),
        .new_sample_in        (new_sample_in),
        .decim_sel            (decim_sel),
        .trig_level           (trig_level),
        .mode                 (mode),
        .arm                  (arm),
        .wave_display_idle_in (wave_display_idle_in),
        .read_index           (read_index),
        .cap_sample_ready     (cap_sample_ready),
        .cap_sample           (cap_sample),
        .cap_display_idle     (cap_display_idle),
        .frame_count          (frame_count),
        .ctrl_state           (ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int d;
        bit swap;
        bit qual;
        if (reset) begin
            m_state = 0; m_fc = 0; m_n = 0; m_prev_sel = 0;
            m_prev_rd = 1'b0; m_pulse = 1'b0; m_last = '0;
        end else begin
            swap = (read_index != m_prev_rd);
            if (mode == 2'd0) m_state = 1;
            else if (mode == 2'd2) begin
                if (m_state == 0 || m_state == 1) m_state = 3;
                else if (m_state == 3 && arm) m_state = 2;
                else if (m_state == 2 && swap) m_state = 3;
            end else m_state = 0;
            if (swap) m_fc = (m_fc + 1) % 65536;
            m_prev_rd = read_index;
            if (int'(decim_sel) != m_prev_sel) m_n = 0;
            m_prev_sel = int'(decim_sel);
            qual = new_sample_ready && ((m_n % (1 << decim_sel)) == 0);
            if (new_sample_ready) m_n++;
            m_pulse = qual;
            if (qual) begin
                d = $signed(new_sample_in) - $signed(trig_level);
                if (d > 32767) d = 32767;
                if (d < -32768) d = -32768;
                m_last = d[15:0];
                sbq.push_back(m_last);
            end
        end
    end

    always @(posedge clk) begin
        logic [15:0] exp_s;
        #1;
        chk("state", int'(ctrl_state), m_state);
        chk("frame_count", int'(frame_count), m_fc);
        chk("display_idle", int'(cap_display_idle),
            int'(wave_display_idle_in && (m_state == 1 || m_state == 2)));
        chk("sample_ready", int'(cap_sample_ready), int'(m_pulse));
        chk("sample_hold", int'(cap_sample), int'(m_last));
        if (cap_sample_ready) begin
            pulse_cnt++;
            if (sbq.size() == 0) chk("scoreboard_underflow", 1, 0);
            else begin
                exp_s = sbq.pop_front();
                chk("scoreboard", int'(cap_sample), int'(exp_s));
            end
        end
    end

    // Advance to the next negedge; pulses drop and wave_capture is emulated.
    task automatic nxt();
        @(negedge clk);
        new_sample_ready = 1'b0;
        arm = 1'b0;
        if (auto_swap && cap_display_idle && $urandom_range(0, 1) == 1) read_index = ~read_index;
    endtask

    logic [15:0] lv_in [3] = '{16'h0000, 16'h7FFF, 16'h8000};
    logic [15:0] lv_exp[3] = '{16'hF000, 16'h6FFF, 16'h8000};

    initial begin
        int p0;
        int fc1;
        repeat (3) nxt();
        chk("rst_state", int'(ctrl_state), 0);
        chk("rst_ready", int'(cap_sample_ready), 0);
        chk("rst_sample", int'(cap_sample), 0);
        chk("rst_fc", int'(frame_count), 0);
        reset = 1'b0;

        decim_sel = 3'd2;
        nxt(); nxt();
        p0 = pulse_cnt;
        for (int i = 0; i < 12; i++) begin
            new_sample_ready = 1'b1;
            new_sample_in = 16'($urandom);
            nxt();
            chk("decim_pick", int'(cap_sample_ready), int'(i % 4 == 0));
            nxt();
        end
        chk("decim_pulses", pulse_cnt - p0, 3);

        decim_sel = 3'd0;
        trig_level = 16'h1000;
        nxt();
        for (int i = 0; i < 3; i++) begin
            new_sample_ready = 1'b1;
            new_sample_in = lv_in[i];
            nxt();
            chk("level_shift", int'(cap_sample), int'(lv_exp[i]));
            nxt();
        end

        mode = 2'd0;
        wave_display_idle_in = 1'b1;
        nxt();
        for (int i = 0; i < 3; i++) begin
            read_index = ~read_index;
            nxt(); nxt();
        end
        chk("run_frames", int'(frame_count), 3);
        chk("run_idle_hi", int'(cap_display_idle), 1);
        wave_display_idle_in = 1'b0;
        #1 chk("run_idle_lo", int'(cap_display_idle), 0);
        wave_display_idle_in = 1'b1;

        fc1 = int'(frame_count);
        mode = 2'd2;
        nxt(); nxt();
        chk("single_done", int'(ctrl_state), 3);
        chk("single_gated", int'(cap_display_idle), 0);
        auto_swap = 1'b1;
        arm = 1'b1;
        nxt();
        for (int k = 0; k < 40 && ctrl_state != 2'd3; k++) nxt();
        repeat (5) nxt();
        chk("single_state", int'(ctrl_state), 3);
        chk("single_one_swap", int'(frame_count), fc1 + 1);
        chk("single_idle", int'(cap_display_idle), 0);

        arm = 1'b1;
        mode = 2'd1;
        nxt();
        chk("arm_vs_stop", int'(ctrl_state), 0);
        chk("arm_vs_stop_fc", int'(frame_count), fc1 + 1);
        mode = 2'd2;
        auto_swap = 1'b0;
        nxt(); nxt();
        arm = 1'b1;
        nxt();
        chk("armed", int'(ctrl_state), 2);
        reset = 1'b1;
        read_index = 1'b0;
        nxt();
        chk("abort_state", int'(ctrl_state), 0);
        chk("abort_ready", int'(cap_sample_ready), 0);
        chk("abort_sample", int'(cap_sample), 0);
        chk("abort_fc", int'(frame_count), 0);
        chk("abort_idle", int'(cap_display_idle), 0);
        reset = 1'b0;

        auto_swap = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 99) == 0) decim_sel = 3'($urandom);
            if ($urandom_range(0, 199) == 0) trig_level = 16'($urandom);
            wave_display_idle_in = ($urandom_range(0, 3) != 0);
            new_sample_ready = ($urandom_range(0, 2) == 0);
            new_sample_in = 16'($urandom);
            arm = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 299) == 0);
            if (reset) read_index = 1'b0;
            nxt();
        end
        reset = 1'b0;
        repeat (3) nxt();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Port clk, input, 1: system clock; every register updates on its rising edge.
REQ-002 Port reset, input, 1: synchronous, active-high reset.
REQ-003 Port new_sample_ready, input, 1: one-cycle strobe from the audio path marking a new sample.
REQ-004 Port new_sample_in, input, 16: signed two's-complement audio sample, valid while new_sample_ready is high.
REQ-005 Port decim_sel, input, 3: decimation select, passes 1 of every 2^decim_sel strobes.
REQ-006 Port trig_level, input, 16: signed trigger level.
REQ-007 Port mode, input, 2: capture mode, 0=RUN, 1=STOP, 2=SINGLE, 3=reserved and treated as STOP.
REQ-008 Port arm, input, 1: one-cycle pulse that re-arms single-shot capture.
REQ-009 Port wave_display_idle_in, input, 1: idle flag from the display.
REQ-010 Port read_index, input, 1: buffer index reported by wave_capture.
REQ-011 Port cap_sample_ready, output, 1: decimated strobe driven to wave_capture new_sample_ready.
REQ-012 Port cap_sample, output, 16: level-shifted sample driven to wave_capture new_sample_in.
REQ-013 Port cap_display_idle, output, 1: gated idle flag driven to wave_capture wave_display_idle.
REQ-014 Port frame_count, output, 16: count of displayed-frame swaps.
REQ-015 Port ctrl_state, output, 2: current FSM state.

Function
REQ-016 Decimation counter (7 bit) SHALL advance on each new_sample_ready and wrap modulo 2^decim_sel; a strobe SHALL qualify when the counter equals 0.
REQ-017 Any change of decim_sel SHALL clear the counter, so the next strobe qualifies; decim_sel=0 SHALL qualify every strobe.
REQ-018 On a qualifying strobe, cap_sample SHALL load new_sample_in minus trig_level, computed at 17 bits and saturated to 0x7FFF/0x8000.
REQ-019 cap_sample_ready SHALL pulse for exactly one cycle, one cycle after the qualifying strobe; cap_sample SHALL hold until the next load.
REQ-020 Decimation and level shifting SHALL run in every FSM state, so capture into the back buffer never stops.
REQ-021 A buffer swap SHALL be detected as read_index differing from its one-cycle-delayed copy; frame_count SHALL increment by 1 per swap, wrapping 0xFFFF->0x0000.
REQ-022 FSM states SHALL be STOP=0, RUN=1, S_ARMED=2, S_DONE=3.
REQ-023 Mode transitions: mode RUN -> RUN; mode STOP or reserved -> STOP; mode SINGLE entered from STOP or RUN -> S_DONE.
REQ-024 In mode SINGLE: S_DONE with arm -> S_ARMED; S_ARMED with a swap detected -> S_DONE; arm in S_ARMED SHALL be ignored.
REQ-025 A mode change SHALL take priority over a simultaneous arm or swap in the same cycle.
REQ-026 cap_display_idle SHALL equal wave_display_idle_in in RUN and S_ARMED and SHALL be 0 in STOP and S_DONE (combinational gate, zero latency).
REQ-027 Gating idle SHALL therefore freeze the displayed buffer in STOP and S_DONE; S_ARMED SHALL permit exactly one swap.

Reset
REQ-028 While reset is high, state SHALL be STOP, and cap_sample_ready, cap_sample, frame_count, the decimation counter and the delayed read_index copy SHALL all be 0.
REQ-029 Reset asserted mid-operation SHALL abort any single-shot in progress, and the first cycle after reset SHALL count no swap (read_index also resets to 0).

Structure
REQ-030 Mode encodings and FSM state encodings SHALL live in the shared capture defines header, reused by the UI block.
REQ-031 Decimation SHALL be one sub-module, sample_decimator (ports clk, reset, strobe_in, decim_sel, strobe_out).
REQ-032 All state SHALL be held in the codebase's dffr/dffre flop primitives; the FSM next-state logic SHALL be a single combinational block.

Verification
REQ-033 decim_sel=2 with 12 strobes -> exactly 3 cap_sample_ready pulses, on strobes 1, 5 and 9, each one cycle late.
REQ-034 trig_level=0x1000 with samples 0x0000, 0x7FFF, 0x8000 -> cap_sample 0xF000, 0x6FFF, 0x8000 (saturated).
REQ-035 mode=RUN with idle high and 3 read_index toggles -> frame_count=3 and cap_display_idle follows idle.
REQ-036 mode=SINGLE then arm, with idle held high -> exactly 1 swap, state S_DONE, cap_display_idle=0, and frame_count +1 only.
REQ-037 Arm and mode=STOP in the same cycle -> state STOP with no swap; reset asserted in S_ARMED -> STOP with all outputs 0.
